// File: rtl/sqrt_ctrl.sv
// Sequencing FSM for the odd-number-subtraction square-root datapath.
// Optional iteration-limit guard compiled in with `define SQRT_CTRL_TIMEOUT_EN.
module sqrt_ctrl #(
    parameter int unsigned MAX_ITER = 256
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       sq_le_x_i,
    output logic       load_x_o,
    output logic       reg_init_o,
    output logic       step_en_o,
    output logic       res_en_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o,
    output logic [8:0] iter_count_o
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StInit   = 3'd1;
    localparam logic [2:0] StCheck  = 3'd2;
    localparam logic [2:0] StUpdate = 3'd3;
    localparam logic [2:0] StFin    = 3'd4;
    localparam logic [2:0] StErr    = 3'd5;

    localparam logic [8:0] MaxIterW = 9'(MAX_ITER);

    logic [2:0] state_q, state_d;
    logic [8:0] iter_q, iter_d;

`ifndef SQRT_CTRL_TIMEOUT_EN
    logic unused_max_iter;
    assign unused_max_iter = ^MaxIterW;
`endif

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StInit;
            end
            StInit: begin
                // An aborted INIT leaves the previous count visible.
                if (!abort_i) iter_d = '0;
                state_d = StCheck;
            end
            StCheck: begin
`ifdef SQRT_CTRL_TIMEOUT_EN
                if (sq_le_x_i && (iter_q == MaxIterW)) state_d = StErr;
                else if (sq_le_x_i)                    state_d = StUpdate;
                else                                   state_d = StFin;
`else
                state_d = sq_le_x_i ? StUpdate : StFin;
`endif
            end
            StUpdate: begin
                // step_en fires this cycle even if aborted, so the step is counted.
                if (iter_q != 9'd511) iter_d = iter_q + 9'd1;
                state_d = StCheck;
            end
            StFin: begin
                state_d = StIdle;
            end
`ifdef SQRT_CTRL_TIMEOUT_EN
            StErr: begin
                state_d = StIdle;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
        if (abort_i && (state_q != StIdle)) state_d = StIdle;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        load_x_o   = (state_q == StInit);
        reg_init_o = (state_q == StInit);
        step_en_o  = (state_q == StUpdate);
        res_en_o   = (state_q == StFin);
        busy_o     = (state_q != StIdle);
`ifdef SQRT_CTRL_TIMEOUT_EN
        done_o     = (state_q == StFin) || (state_q == StErr);
        error_o    = (state_q == StErr);
`else
        done_o     = (state_q == StFin);
        error_o    = 1'b0;
`endif
    end

    assign iter_count_o = iter_q;

endmodule

// File: tb/tb_sqrt_ctrl.sv
// Scoreboard bench for sqrt_ctrl with a behavioural square/delta datapath model.
module tb_sqrt_ctrl;

`ifdef SQRT_CTRL_TIMEOUT_EN
    localparam int  MaxIter   = 4;
    localparam bit  TimeoutEn = 1'b1;
`else
    localparam int  MaxIter   = 256;
    localparam bit  TimeoutEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       sq_le_x;
    logic       load_x, reg_init, step_en, res_en, busy, done, error;
    logic [8:0] iter_count;

    logic [15:0] x_in = '0;
    logic [15:0] x_q;
    logic [17:0] sq_q, dl_q;
    bit          stuck = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         cyc;
        logic [8:0] cnt;
        logic       err;
    } exp_t;
    exp_t sb[$];

    sqrt_ctrl #(.MAX_ITER(MaxIter)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .abort_i      (abort),
        .sq_le_x_i    (sq_le_x),
        .load_x_o     (load_x),
        .reg_init_o   (reg_init),
        .step_en_o    (step_en),
        .res_en_o     (res_en),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
        .iter_count_o (iter_count)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: square starts at 1, delta at 3.
    always @(posedge clk) begin
        if (load_x) x_q <= x_in;
        if (reg_init) begin
            sq_q <= 18'd1;
            dl_q <= 18'd3;
        end else if (step_en) begin
            sq_q <= sq_q + dl_q;
            dl_q <= dl_q + 18'd2;
        end
    end
    assign sq_le_x = stuck ? 1'b1 : (sq_q <= {2'b00, x_q});

    function automatic int isqrt(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    task automatic run_op(input logic [15:0] x, input bit stk);
        exp_t e, got;
        int   r, cyc, steps;
        bit   seen, excl_bad;
        r = stk ? 100000 : isqrt(int'(x));
        e.err = TimeoutEn && (r > MaxIter);
        e.cnt = e.err ? 9'(MaxIter) : 9'(r);
        e.cyc = 2 * int'(e.cnt) + 3;
        sb.push_back(e);
        x_in  = x;
        stuck = stk;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; steps = 0; seen = 0; excl_bad = 0;
        checks++;
        if (!(load_x && reg_init && busy))
            begin errors++; $display("FAIL init_strobes x=%0d: got load_x=%b reg_init=%b busy=%b want 1 1 1",
                                     x, load_x, reg_init, busy); end
        while (!seen && cyc < 700) begin
            if (step_en) steps++;
            if ((int'(load_x | reg_init) + int'(step_en) + int'(res_en)) > 1) excl_bad = 1;
            if (done) seen = 1;
            else begin @(posedge clk); #1; cyc++; end
        end
        got = sb.pop_front();
        checks++;
        if (!seen) begin
            errors++; $display("FAIL done_timeout x=%0d: got no done in %0d cycles want cycle %0d", x, cyc, got.cyc);
        end else begin
            checks++;
            if (cyc !== got.cyc)
                begin errors++; $display("FAIL done_cycle x=%0d: got %0d want %0d", x, cyc, got.cyc); end
            checks++;
            if (iter_count !== got.cnt)
                begin errors++; $display("FAIL iter_count x=%0d: got %0d want %0d", x, iter_count, got.cnt); end
            checks++;
            if (steps !== int'(got.cnt))
                begin errors++; $display("FAIL step_pulses x=%0d: got %0d want %0d", x, steps, got.cnt); end
            checks++;
            if (error !== got.err || res_en !== !got.err)
                begin errors++; $display("FAIL err_res x=%0d: got error=%b res_en=%b want %b %b",
                                         x, error, res_en, got.err, !got.err); end
            checks++;
            if (excl_bad)
                begin errors++; $display("FAIL strobe_exclusive x=%0d: got overlap want none", x); end
        end
        stuck = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if ({load_x, reg_init, step_en, res_en, busy, done, error} !== 7'b0 || iter_count !== 9'd0)
                begin errors++; $display("FAIL reset_outputs: got %b cnt=%0d want 0000000 cnt=0",
                    {load_x, reg_init, step_en, res_en, busy, done, error}, iter_count); end
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0)
            begin errors++; $display("FAIL idle_after_reset: got busy=%b want 0", busy); end
    endtask

    task automatic test_basic();
        run_op(16'd0, 1'b0);
        @(posedge clk); #1;
        run_op(16'd49, 1'b0);
        @(posedge clk); #1;
        run_op(16'hFFFF, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int cyc;
        x_in  = 16'd100;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (cyc = 1; cyc < 9; cyc++) begin
            start = (cyc == 4);
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++;
        if (step_en !== 1'b1 || iter_count !== 9'd3)
            begin errors++; $display("FAIL fourth_update: got step_en=%b cnt=%0d want 1 3", step_en, iter_count); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || res_en !== 1'b0 || iter_count !== 9'd4)
            begin errors++; $display("FAIL abort_update: got busy=%b done=%b res_en=%b cnt=%0d want 0 0 0 4",
                                     busy, done, res_en, iter_count); end
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0)
                begin errors++; $display("FAIL start_not_queued: got busy=%b done=%b want 0 0", busy, done); end
        end
        // start and abort together in IDLE: start wins, abort then kills INIT.
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (load_x !== 1'b1 || busy !== 1'b1)
            begin errors++; $display("FAIL start_beats_abort: got load_x=%b busy=%b want 1 1", load_x, busy); end
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || iter_count !== 9'd4)
            begin errors++; $display("FAIL abort_init: got busy=%b cnt=%0d want 0 4", busy, iter_count); end
        run_op(16'd49, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        run_op(16'd30, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            begin errors++; $display("FAIL idle_after_done: got busy=%b done=%b want 0 0", busy, done); end
        run_op(16'd1, 1'b0);
        @(posedge clk); #1;
        run_op(16'd255, 1'b0);
        @(posedge clk); #1;
    endtask

`ifdef SQRT_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        run_op(16'd0, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || error !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL err_one_cycle: got done=%b error=%b busy=%b want 0 0 0",
                                     done, error, busy); end
    endtask
`else
    task automatic test_saturate();
        bit busy_bad, err_bad;
        busy_bad = 0; err_bad = 0;
        stuck = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (1100) begin
            if (!busy) busy_bad = 1;
            if (error || done) err_bad = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (busy_bad)
            begin errors++; $display("FAIL sat_busy: got busy dropped want busy held"); end
        checks++;
        if (err_bad)
            begin errors++; $display("FAIL sat_no_done: got error/done pulse want none"); end
        checks++;
        if (iter_count !== 9'd511)
            begin errors++; $display("FAIL sat_count: got %0d want 511", iter_count); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        stuck = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || iter_count !== 9'd511)
            begin errors++; $display("FAIL sat_abort: got busy=%b done=%b cnt=%0d want 0 0 511",
                                     busy, done, iter_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_abort();
        test_back_to_back();
`ifdef SQRT_CTRL_TIMEOUT_EN
        test_timeout();
`else
        test_saturate();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
